// File: rtl/fpa_pkg.sv
// Shared definitions for the shared floating-point adder controller:
// word widths and the controller state encoding.
package fpa_pkg;

   localparam int FP_W    = 32;
   localparam int OPCNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } fpa_ctrl_state_t;

endpackage

// File: rtl/fpa.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// with gradual underflow; OF flags a finite sum that rounded to infinity.
module fpa
   import fpa_pkg::*;
(
   input  logic [FP_W-1:0] A,
   input  logic [FP_W-1:0] B,
   output logic [FP_W-1:0] O,
   output logic            OF
);

   localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

   logic        a_nan, b_nan, a_inf, b_inf, swap, sx, sy, sticky, rnd_up;
   logic [9:0]  ex, ey, d, e_r;
   logic [23:0] mx, my;
   logic [26:0] mx_e, my_e, my_sh, m;
   logic [27:0] sum;
   logic [24:0] mant;

   // NOTE: every variable gets a value before any branch so no latch is inferred.
   always_comb begin
      a_nan  = (A[30:23] == 8'hFF) && (A[22:0] != '0);
      b_nan  = (B[30:23] == 8'hFF) && (B[22:0] != '0);
      a_inf  = (A[30:23] == 8'hFF) && (A[22:0] == '0);
      b_inf  = (B[30:23] == 8'hFF) && (B[22:0] == '0);
      swap   = B[30:0] > A[30:0];
      sx     = swap ? B[31] : A[31];
      sy     = swap ? A[31] : B[31];
      ex     = {2'b00, (swap ? B[30:23] : A[30:23])};
      ey     = {2'b00, (swap ? A[30:23] : B[30:23])};
      mx     = {(ex != '0), (swap ? B[22:0] : A[22:0])};
      my     = {(ey != '0), (swap ? A[22:0] : B[22:0])};
      // Subnormals share the exponent of the smallest normal number.
      if (ex == '0) ex = 10'd1;
      if (ey == '0) ey = 10'd1;
      d      = ex - ey;
      mx_e   = {mx, 3'b000};
      my_e   = {my, 3'b000};
      sticky = 1'b0;
      if (d > 10'd26) begin
         my_sh = {26'b0, |my_e};
      end else begin
         sticky = |(my_e & ((27'd1 << d) - 27'd1));
         my_sh  = (my_e >> d) | {26'b0, sticky};
      end

      if (sx == sy) sum = {1'b0, mx_e} + {1'b0, my_sh};
      else          sum = {1'b0, mx_e} - {1'b0, my_sh};

      e_r = ex;
      if (sum[27]) begin
         m   = {sum[27:2], sum[1] | sum[0]};
         e_r = ex + 10'd1;
      end else begin
         m = sum[26:0];
         for (int i = 0; i < 26; i++) begin
            if (!m[26] && e_r > 10'd1) begin
               m   = m << 1;
               e_r = e_r - 10'd1;
            end
         end
      end

      rnd_up = m[2] & (m[3] | m[1] | m[0]);
      mant   = {1'b0, m[26:3]} + {24'b0, rnd_up};
      if (mant[24]) begin
         mant = mant >> 1;
         e_r  = e_r + 10'd1;
      end

      OF = 1'b0;
      if (a_nan || b_nan || (a_inf && b_inf && (A[31] != B[31]))) begin
         O = QNAN;
      end else if (a_inf) begin
         O = A;
      end else if (b_inf) begin
         O = B;
      end else if (e_r >= 10'd255) begin
         O  = {sx, 8'hFF, 23'b0};
         OF = 1'b1;
      end else if (m == '0) begin
         O = {sx & sy, 31'b0};
      end else begin
         O = {sx, (mant[23] ? e_r[7:0] : 8'h00), mant[22:0]};
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or above
// ptr (wrapping modulo NREQ) wins.
module rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             any
);

   int j;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      j       = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!any && req[j]) begin
            any     = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/fpa_share_ctrl.sv
// Shares one fpa adder among NREQ requesters: round-robin grant, one
// operation in flight, result returned over a valid/ready channel.
module fpa_share_ctrl
   import fpa_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*FP_W-1:0] req_a,
   input  logic [NREQ*FP_W-1:0] req_b,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [FP_W-1:0]      rsp_data,
   output logic                 rsp_of,
   output logic                 busy,
   output logic [OPCNT_W-1:0]   op_count
);

   fpa_ctrl_state_t      state;
   logic [IDX_W-1:0]     rr_ptr, gnt_idx;
   logic [FP_W-1:0]      op_a, op_b, res_q, fpa_o;
   logic                 of_q, fpa_of;
   logic [NREQ-1:0]      rsp_valid_q;
   logic [OPCNT_W-1:0]   op_count_q;
   logic [NREQ-1:0]      arb_gnt;
   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_any;

   rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   fpa u_fpa (
      .A  (op_a),
      .B  (op_b),
      .O  (fpa_o),
      .OF (fpa_of)
   );

   // Ready is offered in the same cycle as the request; held off during reset.
   assign req_ready = (state == IDLE && !rst) ? arb_gnt : '0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = res_q;
   assign rsp_of    = of_q;
   assign busy      = (state != IDLE);
   assign op_count  = op_count_q;

   // NOTE: state is updated with non-blocking assignments only, so every
   // branch sees the values from the start of the cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         gnt_idx     <= '0;
         op_a        <= '0;
         op_b        <= '0;
         res_q       <= '0;
         of_q        <= 1'b0;
         rsp_valid_q <= '0;
         op_count_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_any) begin
                  op_a    <= req_a[FP_W*arb_idx +: FP_W];
                  op_b    <= req_b[FP_W*arb_idx +: FP_W];
                  gnt_idx <= arb_idx;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               res_q       <= fpa_o;
               of_q        <= fpa_of;
               rsp_valid_q <= NREQ'(1) << gnt_idx;
               state       <= RESP;
            end
            RESP: begin
               if (rsp_ready[gnt_idx]) begin
                  rsp_valid_q <= '0;
                  rr_ptr      <= (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                  op_count_q  <= op_count_q + 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpa_share_ctrl.sv
// Directed bench for fpa_share_ctrl with NREQ=4: single op, round-robin
// stream, backpressure, adder passthrough, reset abort and counter wrap.
module tb_fpa_share_ctrl;

   localparam int NREQ = 4;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*32-1:0] req_a;
   logic [NREQ*32-1:0] req_b;
   logic [NREQ-1:0]   rsp_valid;
   logic [NREQ-1:0]   rsp_ready;
   logic [31:0]       rsp_data;
   logic              rsp_of;
   logic              busy;
   logic [15:0]       op_count;

   int n_tests = 0;
   int n_fail  = 0;

   fpa_share_ctrl #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_of    (rsp_of),
      .busy      (busy),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] z4(input logic [3:0] v);
      return {28'b0, v};
   endfunction

   // Advance one clock and settle 2 time units after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Single requester: accept in the current cycle, result two cycles later.
   task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_of);
      logic [3:0] oh;
      oh = 4'b0001 << idx;
      req_a[32*idx +: 32] = a;
      req_b[32*idx +: 32] = b;
      req_valid = oh;
      rsp_ready = 4'hF;
      #1;
      check("op_req_ready", z4(req_ready), z4(oh));
      cyc();
      req_valid = '0;
      #1;
      check("op_exec_busy", {31'b0, busy}, 32'd1);
      check("op_exec_no_rsp", z4(rsp_valid), 32'd0);
      cyc();
      check("op_rsp_valid", z4(rsp_valid), z4(oh));
      check("op_rsp_data", rsp_data, exp_d);
      check("op_rsp_of", {31'b0, rsp_of}, {31'b0, exp_of});
      cyc();
      check("op_rsp_done", z4(rsp_valid), 32'd0);
   endtask

   logic [31:0] exp_stream [4];
   logic [31:0] held;
   logic [3:0]  oh;
   logic [15:0] cnt;

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = '0;
      cyc();
      cyc();

      // Reset state
      check("rst_req_ready", z4(req_ready), 32'd0);
      check("rst_rsp_valid", z4(rsp_valid), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_of", {31'b0, rsp_of}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_op_count", {16'b0, op_count}, 32'd0);
      rst = 1'b0;
      cyc();

      // Single request: 1.0 + 2.0 = 3.0
      do_op(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
      check("single_op_count", {16'b0, op_count}, 32'd1);
      check("single_idle", {31'b0, busy}, 32'd0);

      // Passthrough of adder corner cases
      do_op(1, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0);
      do_op(3, 32'h40A0_0000, 32'h0000_0000, 32'h40A0_0000, 1'b0);
      do_op(2, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1);
      check("pass_op_count", {16'b0, op_count}, 32'd4);

      // All four valid from reset, rsp_ready tied high
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("stream_rst_count", {16'b0, op_count}, 32'd0);
      req_a = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
      req_b = {4{32'h3F80_0000}};
      exp_stream = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
      req_valid = 4'hF;
      rsp_ready = 4'hF;
      #1;
      for (int k = 0; k < 5; k++) begin
         oh = 4'b0001 << (k % 4);
         check("stream_grant", z4(req_ready), z4(oh));
         cyc();
         check("stream_exec_busy", {31'b0, busy}, 32'd1);
         check("stream_exec_ready", z4(req_ready), 32'd0);
         cyc();
         check("stream_rsp_valid", z4(rsp_valid), z4(oh));
         check("stream_rsp_data", rsp_data, exp_stream[k % 4]);
         cyc();
         if (k == 4) req_valid = '0;
         #1;
      end
      check("stream_count", {16'b0, op_count}, 32'd5);
      check("stream_withdrawn_ready", z4(req_ready), 32'd0);
      cyc();
      check("stream_withdrawn_busy", {31'b0, busy}, 32'd0);

      // Move rr_ptr to 2 by serving requester 1 alone: 1.0 + 1.0 = 2.0
      do_op(1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);

      // Backpressure on requester 2 while requester 1 waits
      req_a[32*2 +: 32] = 32'h4040_0000;
      req_b[32*2 +: 32] = 32'h3F80_0000;
      req_valid = 4'b0110;
      rsp_ready = 4'b1011;
      #1;
      check("bp_grant2", z4(req_ready), 32'h4);
      cyc();
      req_valid = 4'b0010;
      #1;
      check("bp_exec_ready", z4(req_ready), 32'd0);
      cyc();
      held = rsp_data;
      check("bp_rsp_data", rsp_data, 32'h4080_0000);
      for (int k = 0; k < 5; k++) begin
         cyc();
         check("bp_hold_valid", z4(rsp_valid), 32'h4);
         check("bp_hold_data", rsp_data, held);
         check("bp_hold_ready", z4(req_ready), 32'd0);
      end
      check("bp_count_stalled", {16'b0, op_count}, 32'd6);
      rsp_ready = 4'hF;
      cyc();
      check("bp_count_done", {16'b0, op_count}, 32'd7);
      check("bp_next_grant1", z4(req_ready), 32'h2);
      cyc();
      req_valid = '0;
      cyc();
      check("bp_req1_valid", z4(rsp_valid), 32'h2);
      check("bp_req1_data", rsp_data, 32'h4000_0000);
      cyc();
      check("bp_req1_count", {16'b0, op_count}, 32'd8);

      // Reset pulse while in EXEC aborts the operation
      req_a[31:0] = 32'h3F80_0000;
      req_b[31:0] = 32'h3F80_0000;
      req_valid = 4'b0001;
      #1;
      check("rexec_ready", z4(req_ready), 32'h1);
      cyc();
      req_valid = '0;
      rst = 1'b1;
      #1;
      check("rexec_in_exec", {31'b0, busy}, 32'd1);
      cyc();
      rst = 1'b0;
      #1;
      check("rexec_no_rsp", z4(rsp_valid), 32'd0);
      check("rexec_idle", {31'b0, busy}, 32'd0);
      check("rexec_count", {16'b0, op_count}, 32'd0);
      cyc();
      check("rexec_still_no_rsp", z4(rsp_valid), 32'd0);
      do_op(3, 32'h40A0_0000, 32'h40A0_0000, 32'h4120_0000, 1'b0);
      check("rexec_after_count", {16'b0, op_count}, 32'd1);

      // Counter wrap 0xFFFF -> 0x0000
      force dut.op_count_q = 16'hFFFF;
      #1;
      release dut.op_count_q;
      cnt = op_count;
      check("wrap_preset", {16'b0, cnt}, 32'h0000_FFFF);
      cyc();
      do_op(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
      check("wrap_count", {16'b0, op_count}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
